// File: rtl/ps2_pkg.sv
// ps2_pkg: shared sequencer states, error codes, PS/2 protocol constants and parity helper
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        TX_BITS,
        LINE_ACK,
        WAIT_RESP,
        NEXT
    } ps2_state_t;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT   = 2'b01;
    localparam logic [1:0] ERR_LINE_NACK = 2'b10;
    localparam logic [1:0] ERR_RESEND    = 2'b11;

    localparam logic [7:0] PS2_ACK      = 8'hFA;
    localparam logic [7:0] PS2_RESEND   = 8'hFE;
    localparam logic [7:0] PS2_CMD_LEDS = 8'hED;

    localparam int PS2_FRAME_LEN = 11;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_tx_shifter.sv
// ps2_tx_shifter: host-to-device frame shifter; drives start/data/parity/stop on device clock falls
module ps2_tx_shifter
    import ps2_pkg::*;
(
    input  logic       computerClk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       clk_fall,
    input  logic       dat_sync,
    input  logic [7:0] byte_in,
    output logic       data_oe,
    output logic       line_ack_ok,
    output logic       line_ack_bad
);

    localparam logic [3:0] LAST = 4'(PS2_FRAME_LEN - 1);

    logic [3:0] n;
    logic       active;

    // Start bit on start, then data LSB first, parity, stop release, and the device ACK sample on the last fall
    always_ff @(posedge computerClk or negedge rst_n) begin
        if (!rst_n) begin
            n            <= '0;
            active       <= 1'b0;
            data_oe      <= 1'b0;
            line_ack_ok  <= 1'b0;
            line_ack_bad <= 1'b0;
        end else begin
            line_ack_ok  <= 1'b0;
            line_ack_bad <= 1'b0;
            if (abort) begin
                active  <= 1'b0;
                data_oe <= 1'b0;
            end else if (start) begin
                active  <= 1'b1;
                n       <= '0;
                data_oe <= 1'b1;
            end else if (active && clk_fall) begin
                n <= n + 4'd1;
                if (n < 4'd8)
                    data_oe <= ~byte_in[n[2:0]];
                else if (n == 4'd8)
                    data_oe <= ~odd_parity(byte_in);
                else if (n == 4'd9)
                    data_oe <= 1'b0;
                else if (n == LAST) begin
                    active       <= 1'b0;
                    line_ack_ok  <= ~dat_sync;
                    line_ack_bad <= dat_sync;
                end
            end
        end
    end

endmodule

// File: rtl/ps2_cmd_ctrl.sv
// ps2_cmd_ctrl: PS/2 host-to-keyboard command sequencer (inhibit, RTS, shift, line ACK, 0xFA/0xFE wait)
// Build option: define PS2_CMD_RETRY_EN to resend a byte on line NACK or 0xFE up to MAX_RETRY times.
module ps2_cmd_ctrl
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_MS = 20,
    parameter int MAX_RETRY  = 3
) (
    input  logic       computerClk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_byte,
    input  logic       cmd_has_arg,
    input  logic [7:0] cmd_arg,
    input  logic       ps2_kbclk,
    input  logic       ps2_kbdat,
    output logic       ps2_kbclk_oe,
    output logic       ps2_kbdat_oe,
    input  logic       rx_busy,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_enable,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code
);

    localparam logic [31:0] INHIBIT_CYC = 32'(CLK_HZ / 1_000_000 * INHIBIT_US);
    localparam logic [31:0] TIMEOUT_CYC = 32'(TIMEOUT_MS * CLK_HZ / 1000);

    ps2_state_t  state;
    logic [1:0]  kbclk_s, kbdat_s;
    logic        kbclk_q, clk_fall;
    logic [31:0] inh_cnt, wd_cnt;
    logic [7:0]  cmd_q, arg_q, cur_byte;
    logic        has_arg_q, arg_cur, nack_q, rdy_en;
    logic        watching, timeout, acked, fail, start, retry_ok;
    logic        ack_ok, ack_bad;
    logic [1:0]  fail_code;

    // Two-flop synchronisers on the raw lines plus a delayed clock copy for fall detection
    always_ff @(posedge computerClk or negedge rst_n) begin
        if (!rst_n) begin
            kbclk_s <= 2'b11;
            kbdat_s <= 2'b11;
            kbclk_q <= 1'b1;
        end else begin
            kbclk_s <= {kbclk_s[0], ps2_kbclk};
            kbdat_s <= {kbdat_s[0], ps2_kbdat};
            kbclk_q <= kbclk_s[1];
        end
    end

    assign clk_fall  = kbclk_q & ~kbclk_s[1];
    assign cur_byte  = arg_cur ? arg_q : cmd_q;
    assign cmd_ready = rdy_en && state == IDLE && !rx_busy;
    assign watching  = state inside {RTS, TX_BITS, LINE_ACK, WAIT_RESP};
    assign timeout   = watching && wd_cnt == 32'd1;
    assign acked     = state == WAIT_RESP && rx_valid && rx_data == PS2_ACK;
    assign fail      = (state == LINE_ACK && nack_q) ||
                       (state == WAIT_RESP && rx_valid && rx_data == PS2_RESEND);
    assign fail_code = state == LINE_ACK ? ERR_LINE_NACK : ERR_RESEND;
    assign start     = state == INHIBIT && inh_cnt == 32'd0;

`ifdef PS2_CMD_RETRY_EN
    localparam int RW = $clog2(MAX_RETRY + 2);
    logic [RW-1:0] retry_cnt;

    // Resend count for the byte in flight; cleared on accept and whenever a byte is acknowledged
    always_ff @(posedge computerClk or negedge rst_n) begin
        if (!rst_n)
            retry_cnt <= '0;
        else if ((state == IDLE && cmd_valid && cmd_ready) || acked)
            retry_cnt <= '0;
        else if (fail && retry_ok && !timeout)
            retry_cnt <= retry_cnt + 1'b1;
    end

    assign retry_ok = retry_cnt < RW'(MAX_RETRY);
`else
    assign retry_ok = MAX_RETRY < 0;
`endif

    ps2_tx_shifter u_shifter (
        .computerClk  (computerClk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (timeout),
        .clk_fall     (clk_fall),
        .dat_sync     (kbdat_s[1]),
        .byte_in      (cur_byte),
        .data_oe      (ps2_kbdat_oe),
        .line_ack_ok  (ack_ok),
        .line_ack_bad (ack_bad)
    );

    // Main sequencer; clock line, receiver gate and status outputs are registered here
    always_ff @(posedge computerClk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            inh_cnt      <= '0;
            wd_cnt       <= '0;
            cmd_q        <= '0;
            arg_q        <= '0;
            has_arg_q    <= 1'b0;
            arg_cur      <= 1'b0;
            nack_q       <= 1'b0;
            rdy_en       <= 1'b0;
            ps2_kbclk_oe <= 1'b0;
            rx_enable    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            err_code     <= ERR_NONE;
        end else begin
            rdy_en <= 1'b1;
            done   <= 1'b0;
            error  <= 1'b0;
            if (watching)
                wd_cnt <= wd_cnt - 32'd1;
            if (timeout) begin
                state        <= IDLE;
                ps2_kbclk_oe <= 1'b0;
                rx_enable    <= 1'b1;
                error        <= 1'b1;
                err_code     <= ERR_TIMEOUT;
            end else if (fail) begin
                if (retry_ok) begin
                    state        <= INHIBIT;
                    inh_cnt      <= INHIBIT_CYC - 32'd1;
                    ps2_kbclk_oe <= 1'b1;
                    rx_enable    <= 1'b0;
                end else begin
                    state     <= IDLE;
                    rx_enable <= 1'b1;
                    error     <= 1'b1;
                    err_code  <= fail_code;
                end
            end else begin
                case (state)
                    IDLE: if (cmd_valid && cmd_ready) begin
                        cmd_q        <= cmd_byte;
                        arg_q        <= cmd_arg;
                        has_arg_q    <= cmd_has_arg;
                        arg_cur      <= 1'b0;
                        err_code     <= ERR_NONE;
                        state        <= INHIBIT;
                        inh_cnt      <= INHIBIT_CYC - 32'd1;
                        ps2_kbclk_oe <= 1'b1;
                        rx_enable    <= 1'b0;
                    end
                    INHIBIT: if (inh_cnt == 32'd0) begin
                        state        <= RTS;
                        ps2_kbclk_oe <= 1'b0;
                        wd_cnt       <= TIMEOUT_CYC;
                    end else
                        inh_cnt <= inh_cnt - 32'd1;
                    RTS: state <= TX_BITS;
                    TX_BITS: if (ack_ok || ack_bad) begin
                        state  <= LINE_ACK;
                        nack_q <= ack_bad;
                    end
                    LINE_ACK: begin
                        state     <= WAIT_RESP;
                        rx_enable <= 1'b1;
                    end
                    WAIT_RESP: if (acked) state <= NEXT;
                    NEXT: if (has_arg_q && !arg_cur) begin
                        arg_cur      <= 1'b1;
                        state        <= INHIBIT;
                        inh_cnt      <= INHIBIT_CYC - 32'd1;
                        ps2_kbclk_oe <= 1'b1;
                        rx_enable    <= 1'b0;
                    end else begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// tb_ps2_cmd_ctrl: directed bench with a behavioural PS/2 keyboard driving clock/data and replies
module tb_ps2_cmd_ctrl;
    import ps2_pkg::*;

    localparam int INH = 100;
    localparam int TMO = 2000;
    localparam int HP  = 10;

    logic       computerClk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_has_arg = 1'b0, rx_busy = 1'b0, rx_valid = 1'b0;
    logic [7:0] cmd_byte = 8'h00, cmd_arg = 8'h00, rx_data = 8'h00;
    logic       dev_clk = 1'b1, dev_dat = 1'b1;
    logic       ps2_kbclk, ps2_kbdat;
    logic       cmd_ready, ps2_kbclk_oe, ps2_kbdat_oe, rx_enable, done, error;
    logic [1:0] err_code;

    int vectors = 0, miscompares = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, inh_starts = 0, run = 0, last_low = 0;

    assign ps2_kbclk = dev_clk & ~ps2_kbclk_oe;
    assign ps2_kbdat = dev_dat & ~ps2_kbdat_oe;

    ps2_cmd_ctrl #(
        .CLK_HZ(2_000_000), .INHIBIT_US(50), .TIMEOUT_MS(1), .MAX_RETRY(3)
    ) dut (
        .computerClk  (computerClk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_byte     (cmd_byte),
        .cmd_has_arg  (cmd_has_arg),
        .cmd_arg      (cmd_arg),
        .ps2_kbclk    (ps2_kbclk),
        .ps2_kbdat    (ps2_kbdat),
        .ps2_kbclk_oe (ps2_kbclk_oe),
        .ps2_kbdat_oe (ps2_kbdat_oe),
        .rx_busy      (rx_busy),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_enable    (rx_enable),
        .done         (done),
        .error        (error),
        .err_code     (err_code)
    );

    always #5 computerClk = ~computerClk;

    // Pulse counters and inhibit-length measurement
    always @(negedge computerClk) begin
        if (done) done_cnt++;
        if (error) err_cnt++;
        if (done && error) both_cnt++;
        if (ps2_kbclk_oe) begin
            if (run == 0) inh_starts++;
            run++;
        end else if (run != 0) begin
            last_low = run;
            run = 0;
        end
    end

    initial begin
        #900_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge computerClk);
    endtask

    task automatic issue(input logic [7:0] c, input logic ha, input logic [7:0] a);
        @(negedge computerClk);
        check("cmd_ready_idle", 32'(cmd_ready), 1);
        cmd_byte = c; cmd_has_arg = ha; cmd_arg = a; cmd_valid = 1'b1;
        @(negedge computerClk);
        cmd_valid = 1'b0;
    endtask

    task automatic dev_frame(input logic nack_it, output logic [7:0] got, output logic par, output logic stp);
        int n;
        n = 0; got = 8'h00; par = 1'b0; stp = 1'b0;
        while (!ps2_kbclk_oe && n < 5000) begin @(negedge computerClk); n++; end
        while (ps2_kbclk_oe && n < 5000) begin @(negedge computerClk); n++; end
        check("frame_start", 32'(n < 5000), 1);
        check("start_bit", 32'(ps2_kbdat_oe), 1);
        @(negedge computerClk);
        check("inhibit_len", 32'(last_low), INH);
        for (int i = 1; i <= 11; i++) begin
            if (i == 11) dev_dat = nack_it;
            repeat (HP) @(negedge computerClk);
            dev_clk = 1'b0;
            repeat (HP) @(negedge computerClk);
            if (i <= 8) got[i-1] = ps2_kbdat;
            else if (i == 9) par = ps2_kbdat;
            else if (i == 10) stp = ps2_kbdat;
            dev_clk = 1'b1;
        end
        dev_dat = 1'b1;
    endtask

    task automatic dev_reply(input logic [7:0] b);
        repeat (20) @(negedge computerClk);
        rx_data = b; rx_valid = 1'b1;
        @(negedge computerClk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_end(input int base);
        int n;
        n = 0;
        while (done_cnt + err_cnt == base && n < 5000) begin @(negedge computerClk); n++; end
        check("end_event", 32'(n < 5000), 1);
    endtask

    initial begin
        logic [7:0] got;
        logic       par, stp;
        int         bd, be, bi, n;

        cycles(3);
        check("rst_clk_oe", 32'(ps2_kbclk_oe), 0);
        check("rst_dat_oe", 32'(ps2_kbdat_oe), 0);
        check("rst_rx_en", 32'(rx_enable), 1);
        check("rst_ready", 32'(cmd_ready), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_err_code", 32'(err_code), 0);
        rst_n = 1'b1;
        cycles(2);
        check("ready_after_rst", 32'(cmd_ready), 1);

        // LED command with argument, scancode interleaved before the final ACK
        bd = done_cnt; be = err_cnt;
        issue(PS2_CMD_LEDS, 1'b1, 8'h02);
        dev_frame(1'b0, got, par, stp);
        check("f1_byte", 32'(got), 32'hED);
        check("f1_parity", 32'(par), 1);
        check("f1_stop", 32'(stp), 1);
        dev_reply(PS2_ACK);
        dev_frame(1'b0, got, par, stp);
        check("f2_byte", 32'(got), 32'h02);
        check("f2_parity", 32'(par), 0);
        dev_reply(8'h1C);
        dev_reply(PS2_ACK);
        wait_end(bd + be);
        cycles(3);
        check("led_done", 32'(done_cnt - bd), 1);
        check("led_err", 32'(err_cnt - be), 0);
        check("led_code", 32'(err_code), 32'(ERR_NONE));

        // 0xFE response to 0xF4
        bd = done_cnt; be = err_cnt; bi = inh_starts;
        issue(8'hF4, 1'b0, 8'h00);
        dev_frame(1'b0, got, par, stp);
        check("f4_byte", 32'(got), 32'hF4);
        dev_reply(PS2_RESEND);
`ifdef PS2_CMD_RETRY_EN
        dev_frame(1'b0, got, par, stp);
        check("f4_resend_byte", 32'(got), 32'hF4);
        dev_reply(PS2_ACK);
        wait_end(bd + be);
        cycles(3);
        check("fe_fa_done", 32'(done_cnt - bd), 1);
        check("fe_fa_err", 32'(err_cnt - be), 0);
        check("fe_fa_frames", 32'(inh_starts - bi), 2);

        bd = done_cnt; be = err_cnt; bi = inh_starts;
        issue(8'hF4, 1'b0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            dev_frame(1'b0, got, par, stp);
            check("fe4_byte", 32'(got), 32'hF4);
            dev_reply(PS2_RESEND);
        end
        wait_end(bd + be);
        cycles(3);
        check("fe4_err", 32'(err_cnt - be), 1);
        check("fe4_code", 32'(err_code), 32'(ERR_RESEND));
        check("fe4_frames", 32'(inh_starts - bi), 4);

        bd = done_cnt; be = err_cnt;
        issue(8'hF4, 1'b0, 8'h00);
        dev_frame(1'b1, got, par, stp);
        dev_frame(1'b0, got, par, stp);
        check("nack_resend_byte", 32'(got), 32'hF4);
        dev_reply(PS2_ACK);
        wait_end(bd + be);
        cycles(3);
        check("nack_recover_done", 32'(done_cnt - bd), 1);

        bd = done_cnt; be = err_cnt;
        issue(8'hF4, 1'b0, 8'h00);
        for (int k = 0; k < 4; k++) dev_frame(1'b1, got, par, stp);
        wait_end(bd + be);
        cycles(3);
        check("nack4_err", 32'(err_cnt - be), 1);
        check("nack4_code", 32'(err_code), 32'(ERR_LINE_NACK));
`else
        wait_end(bd + be);
        cycles(3);
        check("fe_err", 32'(err_cnt - be), 1);
        check("fe_done", 32'(done_cnt - bd), 0);
        check("fe_code", 32'(err_code), 32'(ERR_RESEND));
        check("fe_frames", 32'(inh_starts - bi), 1);

        bd = done_cnt; be = err_cnt;
        issue(8'hF4, 1'b0, 8'h00);
        dev_frame(1'b1, got, par, stp);
        wait_end(bd + be);
        cycles(3);
        check("nack_err", 32'(err_cnt - be), 1);
        check("nack_code", 32'(err_code), 32'(ERR_LINE_NACK));
`endif

        // Silent device: watchdog expiry measured from clock release
        be = err_cnt;
        issue(8'hF4, 1'b0, 8'h00);
        n = 0;
        while (!ps2_kbclk_oe && n < 5000) begin @(negedge computerClk); n++; end
        while (ps2_kbclk_oe && n < 5000) begin @(negedge computerClk); n++; end
        n = 0;
        while (!error && n < TMO + 50) begin @(negedge computerClk); n++; end
        check("timeout_cycles", 32'(n), TMO);
        check("timeout_code", 32'(err_code), 32'(ERR_TIMEOUT));
        cycles(1);
        check("timeout_clk_rel", 32'(ps2_kbclk_oe), 0);
        check("timeout_dat_rel", 32'(ps2_kbdat_oe), 0);
        check("timeout_rx_en", 32'(rx_enable), 1);
        cycles(10);
        check("err_code_held", 32'(err_code), 32'(ERR_TIMEOUT));

        // Receiver busy blocks acceptance
        bi = inh_starts;
        @(negedge computerClk);
        rx_busy = 1'b1; cmd_valid = 1'b1; cmd_byte = 8'hF4;
        cycles(1);
        check("busy_ready", 32'(cmd_ready), 0);
        cycles(20);
        check("busy_no_inhibit", 32'(inh_starts - bi), 0);
        check("busy_clk_oe", 32'(ps2_kbclk_oe), 0);
        cmd_valid = 1'b0; rx_busy = 1'b0;

        // Asynchronous reset in the middle of the data bits
        issue(8'hF0, 1'b0, 8'h00);
        n = 0;
        while (!ps2_kbclk_oe && n < 5000) begin @(negedge computerClk); n++; end
        while (ps2_kbclk_oe && n < 5000) begin @(negedge computerClk); n++; end
        for (int i = 0; i < 3; i++) begin
            repeat (HP) @(negedge computerClk);
            dev_clk = 1'b0;
            repeat (HP) @(negedge computerClk);
            dev_clk = 1'b1;
        end
        check("pre_rst_rx_en", 32'(rx_enable), 0);
        check("pre_rst_dat_oe", 32'(ps2_kbdat_oe), 1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_dat_oe", 32'(ps2_kbdat_oe), 0);
        check("midrst_clk_oe", 32'(ps2_kbclk_oe), 0);
        check("midrst_rx_en", 32'(rx_enable), 1);
        @(negedge computerClk);
        rst_n = 1'b1;
        cycles(3);
        check("post_rst_ready", 32'(cmd_ready), 1);
        check("no_done_err_overlap", 32'(both_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
